// File: rtl/mem_access_unit_if.sv
// Load/store request, response and data-memory bus for mem_access_unit.
// The unit itself is the slave side; the pipeline/memory model is the master.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        mem_enable;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_load, req_size, req_signed,
        input  req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
        output mem_enable, mem_rw, mem_addr, mem_wdata, mem_size
    );

    modport master (
        output req_valid, req_load, req_size, req_signed,
        output req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
        input  mem_enable, mem_rw, mem_addr, mem_wdata, mem_size
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: registers one request, runs a SETUP/STROBE cycle on the
// data memory and returns an extended load result or an error pulse.
module mem_access_unit (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_live;
    logic        r_store;
    logic        r_signed;
    logic        r_err;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_err;
    logic [32:0] w_span;
    logic [32:0] w_last;
    logic [31:0] w_ext;

    assign w_accept = bus.req_valid & bus.req_ready;

    always_comb begin
        w_span = 33'd3;
        unique case (1'b1)
            bus.req_size == 2'b00: w_span = 33'd0;
            bus.req_size == 2'b01: w_span = 33'd1;
            default:               w_span = 33'd3;
        endcase
    end

    // Widened sum so addresses near 2^32 cannot wrap back into range
    assign w_last = {1'b0, bus.req_addr} + w_span;

    assign w_err = (bus.req_size == 2'b11)
                 | ((bus.req_size == 2'b01) & bus.req_addr[0])
                 | ((bus.req_size == 2'b10) & (bus.req_addr[1:0] != 2'b00))
                 | (w_last > 33'd255);

    always_comb begin
        w_ext = bus.mem_rdata;
        unique case (1'b1)
            r_size == 2'b00:
                w_ext = {{24{r_signed & bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
            r_size == 2'b01:
                w_ext = {{16{r_signed & bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
            default:
                w_ext = bus.mem_rdata;
        endcase
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next = w_err ? RESP : SETUP;
            SETUP:   w_next = STROBE;
            STROBE:  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_live   <= 1'b0;
            r_store  <= 1'b0;
            r_signed <= 1'b0;
            r_err    <= 1'b0;
            r_size   <= 2'b00;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
            if (w_accept) begin
                r_store  <= ~bus.req_load;
                r_signed <= bus.req_signed;
                r_err    <= w_err;
                r_size   <= bus.req_size;
                r_addr   <= bus.req_addr;
                r_wdata  <= bus.req_wdata;
                r_rdata  <= '0;
            end
            if (r_state == STROBE && !r_store)
                r_rdata <= w_ext;
        end
    end

    // Memory bus is a straight view of the held request, so it cannot move mid-strobe
    assign bus.req_ready  = r_live & (r_state == IDLE);
    assign bus.rsp_valid  = (r_state == RESP);
    assign bus.rsp_error  = (r_state == RESP) & r_err;
    assign bus.rsp_rdata  = (r_state == RESP) ? r_rdata : 32'd0;
    assign bus.mem_enable = (r_state == STROBE);
    assign bus.mem_rw     = r_store;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_wdata  = r_wdata;
    assign bus.mem_size   = r_size;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 256-byte big-endian memory model.
module tb_mem_access_unit;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   pulses;
    logic [7:0] mem [0:255];
    logic [7:0] ma;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ma = bus.mem_addr[7:0];

    always_comb begin
        bus.mem_rdata = 32'd0;
        case (bus.mem_size)
            2'b00:   bus.mem_rdata = {24'd0, mem[ma]};
            2'b01:   bus.mem_rdata = {16'd0, mem[ma], mem[ma + 8'd1]};
            default: bus.mem_rdata = {mem[ma], mem[ma + 8'd1],
                                      mem[ma + 8'd2], mem[ma + 8'd3]};
        endcase
    end

    always @(posedge clk) begin
        if (bus.mem_enable) begin
            pulses = pulses + 1;
            if (bus.mem_rw) begin
                case (bus.mem_size)
                    2'b00: mem[ma] = bus.mem_wdata[7:0];
                    2'b01: begin
                        mem[ma]        = bus.mem_wdata[15:8];
                        mem[ma + 8'd1] = bus.mem_wdata[7:0];
                    end
                    default: begin
                        mem[ma]        = bus.mem_wdata[31:24];
                        mem[ma + 8'd1] = bus.mem_wdata[23:16];
                        mem[ma + 8'd2] = bus.mem_wdata[15:8];
                        mem[ma + 8'd3] = bus.mem_wdata[7:0];
                    end
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int w;
        w = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        check({tag, " ready"}, {31'd0, bus.req_ready}, 32'd1);
    endtask

    task automatic drive(input logic ld, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd);
        bus.req_valid  = 1'b1;
        bus.req_load   = ld;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
    endtask

    task automatic scramble();
        bus.req_valid  = 1'b0;
        bus.req_load   = ~bus.req_load;
        bus.req_size   = ~bus.req_size;
        bus.req_signed = ~bus.req_signed;
        bus.req_addr   = ~bus.req_addr;
        bus.req_wdata  = ~bus.req_wdata;
    endtask

    task automatic do_req(input string tag, input logic ld, input logic [1:0] sz,
                          input logic sg, input logic [31:0] addr,
                          input logic [31:0] wd, input logic exp_err,
                          input logic [31:0] exp_rd);
        int p0;
        int lat;
        wait_ready(tag);
        drive(ld, sz, sg, addr, wd);
        p0 = pulses;
        @(posedge clk);
        #1 scramble();
        lat = exp_err ? 1 : 3;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            check({tag, " rsp_valid"}, {31'd0, bus.rsp_valid},
                  {31'd0, (k == lat)});
            if (!exp_err && k == 1) begin
                check({tag, " setup en"}, {31'd0, bus.mem_enable}, 32'd0);
                check({tag, " setup addr"}, bus.mem_addr, addr);
            end
            if (!exp_err && k == 2) begin
                check({tag, " strobe en"}, {31'd0, bus.mem_enable}, 32'd1);
                check({tag, " strobe addr"}, bus.mem_addr, addr);
                check({tag, " strobe rw"}, {31'd0, bus.mem_rw}, {31'd0, ~ld});
                check({tag, " strobe size"}, {30'd0, bus.mem_size}, {30'd0, sz});
                check({tag, " strobe wdata"}, bus.mem_wdata, wd);
            end
            if (k == lat) begin
                check({tag, " error"}, {31'd0, bus.rsp_error}, {31'd0, exp_err});
                check({tag, " rdata"}, bus.rsp_rdata, exp_rd);
                check({tag, " resp en"}, {31'd0, bus.mem_enable}, 32'd0);
            end
        end
        @(negedge clk);
        check({tag, " rsp drop"}, {31'd0, bus.rsp_valid}, 32'd0);
        check({tag, " ready back"}, {31'd0, bus.req_ready}, 32'd1);
        check({tag, " pulses"}, pulses - p0, exp_err ? 32'd0 : 32'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        pulses = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_load = 1'b0;
        bus.req_size = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;

        repeat (2) @(negedge clk);
        check("rst ready", {31'd0, bus.req_ready}, 32'd0);
        check("rst rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst rsp_error", {31'd0, bus.rsp_error}, 32'd0);
        check("rst rdata", bus.rsp_rdata, 32'd0);
        check("rst mem_en", {31'd0, bus.mem_enable}, 32'd0);
        check("rst mem_rw", {31'd0, bus.mem_rw}, 32'd0);
        check("rst mem_addr", bus.mem_addr, 32'd0);
        check("rst mem_wdata", bus.mem_wdata, 32'd0);
        check("rst mem_size", {30'd0, bus.mem_size}, 32'd0);
        rst_n = 1'b1;
        #1 check("pre-edge ready", {31'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        check("post-rst ready", {31'd0, bus.req_ready}, 32'd1);

        do_req("sw 10", 1'b0, 2'b10, 1'b0, 32'h10, 32'hA1B2C3D4, 1'b0, 32'd0);
        do_req("lw 10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hA1B2C3D4);
        do_req("sb 13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h12345680, 1'b0, 32'd0);
        do_req("lb 13", 1'b1, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, 32'hFFFFFF80);
        do_req("lbu 13", 1'b1, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 32'h00000080);
        do_req("sh 20", 1'b0, 2'b01, 1'b0, 32'h20, 32'hDEAD8001, 1'b0, 32'd0);
        do_req("lh 20", 1'b1, 2'b01, 1'b1, 32'h20, 32'h0, 1'b0, 32'hFFFF8001);
        do_req("lhu 20", 1'b1, 2'b01, 1'b0, 32'h20, 32'h0, 1'b0, 32'h00008001);
        do_req("lw signed", 1'b1, 2'b10, 1'b1, 32'h10, 32'h0, 1'b0, 32'hA1B2C380);

        do_req("err w22", 1'b1, 2'b10, 1'b0, 32'h22, 32'h0, 1'b1, 32'd0);
        do_req("err h21", 1'b0, 2'b01, 1'b0, 32'h21, 32'h5555, 1'b1, 32'd0);
        do_req("err wFD", 1'b1, 2'b10, 1'b0, 32'hFD, 32'h0, 1'b1, 32'd0);
        do_req("err sz3", 1'b1, 2'b11, 1'b0, 32'h00, 32'h0, 1'b1, 32'd0);
        do_req("err w100", 1'b1, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 32'd0);
        do_req("err hFF", 1'b1, 2'b01, 1'b0, 32'hFF, 32'h0, 1'b1, 32'd0);
        do_req("sw FC", 1'b0, 2'b10, 1'b0, 32'hFC, 32'hCAFEF00D, 1'b0, 32'd0);
        do_req("lw FC", 1'b1, 2'b10, 1'b0, 32'hFC, 32'h0, 1'b0, 32'hCAFEF00D);
        do_req("lbu FF", 1'b1, 2'b00, 1'b0, 32'hFF, 32'h0, 1'b0, 32'h0000000D);

        // Back-to-back: valid held high across three loads
        wait_ready("b2b");
        drive(1'b1, 2'b10, 1'b0, 32'h10, 32'h0);
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            check($sformatf("b2b ready c%0d", c), {31'd0, bus.req_ready},
                  {31'd0, (c % 4 == 0)});
            check($sformatf("b2b rsp c%0d", c), {31'd0, bus.rsp_valid},
                  {31'd0, (c % 4 == 3)});
            if (c == 3) check("b2b rd0", bus.rsp_rdata, 32'hA1B2C380);
            if (c == 7) check("b2b rd1", bus.rsp_rdata, 32'h00008001);
            if (c == 11) check("b2b rd2", bus.rsp_rdata, 32'hFFFFFFC3);
            if (c == 4) drive(1'b1, 2'b01, 1'b0, 32'h20, 32'h0);
            if (c == 8) drive(1'b1, 2'b00, 1'b1, 32'h12, 32'h0);
            if (c == 12) bus.req_valid = 1'b0;
        end

        // Reset pulled during STROBE
        wait_ready("rst mid");
        drive(1'b0, 2'b10, 1'b0, 32'h40, 32'h11111111);
        @(posedge clk);
        #1 scramble();
        @(negedge clk);
        @(negedge clk);
        check("mid strobe en", {31'd0, bus.mem_enable}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid en drop", {31'd0, bus.mem_enable}, 32'd0);
        check("mid rsp", {31'd0, bus.rsp_valid}, 32'd0);
        check("mid ready", {31'd0, bus.req_ready}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("mid no rsp", {31'd0, bus.rsp_valid}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("mid no rsp after", {31'd0, bus.rsp_valid}, 32'd0);
        do_req("lw after rst", 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hA1B2C380);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
